mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the pipelined MIPS core, sitting beside the EX-stage ALU and owning the HI/LO registers.
- It is the producer of multi-cycle stall requests. While an operation is in flight it raises `busy`, and the hazard unit turns that into stallF/stallD/flushE for any MFHI/MFLO/MULT/DIV that reaches decode.
- Implements MULTU, DIVU, MTHI and MTLO.

---
 rtl/mul_div_unit_if.sv | 18 +
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dz;

  modport master (output start, op, sign, a, b, input  busy, done, hi, lo, dz);
  modport slave  (input  start, op, sign, a, b, output busy, done, hi, lo, dz);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULTU/DIVU/MTHI/MTLO unit owning HI/LO; busy stalls the pipe while an op runs.
// Define MDU_SIGNED_EN to add signed MULT/DIV via a trailing FIX (sign-correction) state.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave mdu
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef MDU_SIGNED_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
`endif

  state_e             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;  // multiplicand or divisor magnitude
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept, iterate, finish;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, result;

`ifdef MDU_SIGNED_EN
  logic sa, sb, signed_op, fix_mul, neg_prod, neg_quo, neg_rem;
  assign sa    = mdu.sign & mdu.a[WIDTH-1];
  assign sb    = mdu.sign & mdu.b[WIDTH-1];
  assign a_mag = sa ? -mdu.a : mdu.a;
  assign b_mag = sb ? -mdu.b : mdu.b;
`else
  logic unused_sign;
  assign unused_sign = mdu.sign;
  assign a_mag       = mdu.a;
  assign b_mag       = mdu.b;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift  = acc[2*WIDTH-1:WIDTH-1];
    div_diff   = div_shift - {1'b0, opnd};
    acc_step   = acc;
    result     = acc;
    case (state)
      IDLE: begin
        if (mdu.start && !mdu.op[1]) begin
          accept     = 1'b1;
          state_next = mdu.op[0] ? DIV : MUL;
        end
      end
      MUL, DIV: begin
        iterate = 1'b1;
        if (state == MUL)
          acc_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        else
          acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
        result = acc_step;
        if (cnt == LAST) begin
`ifdef MDU_SIGNED_EN
          state_next = signed_op ? FIX : IDLE;
          finish     = !signed_op;
`else
          state_next = IDLE;
          finish     = 1'b1;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      FIX: begin
        state_next = IDLE;
        finish     = 1'b1;
        if (fix_mul) begin
          result = neg_prod ? -acc : acc;
        end else begin
          result[2*WIDTH-1:WIDTH] = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          result[WIDTH-1:0]       = neg_quo ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the datapath is deliberately not reset; accept reloads it before any cycle reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc      <= {{WIDTH{1'b0}}, (mdu.op[0] ? a_mag : b_mag)};
      opnd     <= mdu.op[0] ? b_mag : a_mag;
      div_zero <= mdu.op[0] && (mdu.b == '0);
`ifdef MDU_SIGNED_EN
      signed_op <= mdu.sign;
      fix_mul   <= !mdu.op[0];
      neg_prod  <= sa ^ sb;
      neg_rem   <= sa;
      neg_quo   <= (sa ^ sb) && (mdu.b != '0);  // divide-by-zero keeps the all-ones quotient
`endif
    end else if (iterate) begin
      acc <= acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept)       cnt <= '0;
      else if (iterate) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (accept)      dz_q <= 1'b0;
      else if (finish) dz_q <= div_zero;
      if (finish) begin
        {hi_q, lo_q} <= result;
      end else if (state == IDLE && mdu.start && mdu.op[1]) begin
        if (mdu.op[0]) lo_q <= mdu.a;
        else           hi_q <= mdu.a;
      end
    end
  end

  assign mdu.busy = (state != IDLE) || (mdu.start && !mdu.op[1]);
  assign mdu.done = done_q;
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;
  assign mdu.dz   = dz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) mdu ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .mdu(mdu));

  int vectors     = 0;
  int miscompares = 0;

  // Architectural model of HI/LO/dz.
  logic [W-1:0] m_hi, m_lo;
  logic         m_dz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one MULTU/DIVU; optionally drive a second start at cycle inject (must be ignored).
  task automatic run_op(input logic [1:0] op_i, input logic sign_i,
                        input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input int inject, input logic [1:0] inject_op);
    logic [63:0]  p;
    logic [W-1:0] e_hi, e_lo;
    logic         e_dz;
    longint       sa, sb, q, r;
    bit           sgn;
    int           lat, cyc, busy_n;
    sgn = 1'b0;
`ifdef MDU_SIGNED_EN
    sgn = sign_i;
`endif
    lat  = W + (sgn ? 1 : 0);
    sa   = longint'($signed(a_i));
    sb   = longint'($signed(b_i));
    e_dz = 1'b0;
    if (!op_i[0]) begin
      if (sgn) p = sa * sb;
      else     p = 64'(a_i) * 64'(b_i);
      {e_hi, e_lo} = p;
    end else if (b_i == 0) begin
      e_lo = '1;
      e_hi = a_i;
      e_dz = 1'b1;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      e_lo = W'(q);
      e_hi = W'(r);
    end else begin
      e_lo = a_i / b_i;
      e_hi = a_i % b_i;
    end

    @(negedge clk);
    mdu.start = 1'b1; mdu.op = op_i; mdu.sign = sign_i; mdu.a = a_i; mdu.b = b_i;
    #1 check("busy_issue", 64'(mdu.busy), 64'd1);
    @(negedge clk);
    mdu.start = 1'b0;
    check("dz_clear", 64'(mdu.dz), 64'd0);
    check("hi_hold", 64'(mdu.hi), 64'(m_hi));
    check("lo_hold", 64'(mdu.lo), 64'(m_lo));
    busy_n = 1;
    cyc    = 1;
    while (mdu.done !== 1'b1 && cyc <= lat + 8) begin
      if (mdu.busy === 1'b1) busy_n++;
      if (cyc == inject) begin
        mdu.start = 1'b1; mdu.op = inject_op; mdu.a = 9; mdu.b = 3;
      end else begin
        mdu.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mdu.start = 1'b0;
    check("done_cycle", 64'(cyc), 64'(lat + 1));
    check("busy_cycles", 64'(busy_n), 64'(lat + 1));
    check("hi_result", 64'(mdu.hi), 64'(e_hi));
    check("lo_result", 64'(mdu.lo), 64'(e_lo));
    check("dz_result", 64'(mdu.dz), 64'(e_dz));
    m_hi = e_hi; m_lo = e_lo; m_dz = e_dz;
    @(negedge clk);
    check("done_pulse", 64'(mdu.done), 64'd0);
    check("busy_after", 64'(mdu.busy), 64'd0);
  endtask

  task automatic mt(input logic hi_sel, input logic [W-1:0] d);
    @(negedge clk);
    mdu.start = 1'b1; mdu.op = hi_sel ? 2'b10 : 2'b11; mdu.a = d;
    #1 check("mt_busy_issue", 64'(mdu.busy), 64'd0);
    @(negedge clk);
    mdu.start = 1'b0;
    if (hi_sel) m_hi = d;
    else        m_lo = d;
    check("mt_busy", 64'(mdu.busy), 64'd0);
    check("mt_done", 64'(mdu.done), 64'd0);
    check("mt_hi", 64'(mdu.hi), 64'(m_hi));
    check("mt_lo", 64'(mdu.lo), 64'(m_lo));
    check("mt_dz", 64'(mdu.dz), 64'(m_dz));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(mdu.busy), 64'd0);
    check({tag, "_done"}, 64'(mdu.done), 64'd0);
    check({tag, "_hi"},   64'(mdu.hi),   64'd0);
    check({tag, "_lo"},   64'(mdu.lo),   64'd0);
    check({tag, "_dz"},   64'(mdu.dz),   64'd0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_seen;
    logic [1:0]   r_op;
    logic [W-1:0] r_a, r_b;

    rst = 1'b1;
    mdu.start = 1'b0; mdu.op = 2'b00; mdu.sign = 1'b0; mdu.a = '0; mdu.b = '0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_op(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 2'b00);
    run_op(2'b01, 1'b0, 32'd100, 32'd7, -1, 2'b00);
    run_op(2'b01, 1'b0, 32'd5, 32'd0, -1, 2'b00);
    run_op(2'b00, 1'b0, 32'd3, 32'd4, -1, 2'b00);
    mt(1'b1, 32'h0000_1234);
    mt(1'b0, 32'hA5A5_0F0F);
    run_op(2'b00, 1'b0, 32'd6, 32'd7, 5, 2'b01);
    run_op(2'b00, 1'b0, 32'd6, 32'd7, 5, 2'b10);
    run_op(2'b00, 1'b0, 32'd6, 32'd7, 5, 2'b11);

    // sign=1 cases: signed with MDU_SIGNED_EN, otherwise sign must be ignored.
    run_op(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd5, -1, 2'b00);
    run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, 2'b00);
    run_op(2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 2'b00);
    run_op(2'b01, 1'b1, 32'hFFFF_FFF9, 32'd0, -1, 2'b00);
    run_op(2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, -1, 2'b00);

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? '0 :
             ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      if (r_op[1]) mt(!r_op[0], r_a);
      else         run_op(r_op, 1'($urandom_range(0, 1)), r_a, r_b, -1, 2'b00);
    end

    // Reset while idle with dz and HI/LO populated.
    run_op(2'b01, 1'b0, 32'd5, 32'd0, -1, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("idle_rst");

    // Reset in cycle 10 of DIVU 100/7: op abandoned, no done pulse.
    mt(1'b1, 32'h0000_BEEF);
    @(negedge clk);
    mdu.start = 1'b1; mdu.op = 2'b01; mdu.sign = 1'b0; mdu.a = 32'd100; mdu.b = 32'd7;
    @(negedge clk);
    mdu.start = 1'b0;
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_rst");
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (mdu.done === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'd0);
    check("mid_rst_hi_kept", 64'(mdu.hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
